// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC and buffers {pc, inst} pairs in a circular queue.
// Optional perf counters are enabled by defining FETCHQ_PERF_EN.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     IMEM_AW  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [IMEM_AW-1:0]         imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [XLEN-1:0]            fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_flushed
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_d [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     inst_mem_d [DEPTH];
    logic            pop_s;
    logic            push_s;

    // Handshake decode, queue/PC next-state; a redirect overrides both push and pop.
    always_comb begin
        pop_s      = (count_q != {CW{1'b0}}) & out_ready;
        push_s     = ~redirect_valid & ((count_q < CW'(DEPTH)) | pop_s);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (redirect_valid) begin
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            count_d    = {CW{1'b0}};
            fetch_pc_d = redirect_pc & ALIGN_MASK;
        end else begin
            if (push_s) begin
                pc_mem_d[wr_ptr_q]   = fetch_pc_q;
                inst_mem_d[wr_ptr_q] = imem_data;
                wr_ptr_d             = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
                fetch_pc_d           = fetch_pc_q + {{(XLEN-3){1'b0}}, 3'b100};
            end else begin
                wr_ptr_d   = wr_ptr_q;
                fetch_pc_d = fetch_pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            end else if (!push_s && pop_s) begin
                count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end
    end

    // Queue and fetch-PC state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            fetch_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= {XLEN{1'b0}};
                inst_mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

    assign imem_addr    = fetch_pc_q[IMEM_AW+1:2];
    assign fetch_pc     = fetch_pc_q;
    assign occupancy    = count_q;
    assign out_valid    = (count_q != {CW{1'b0}});
    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign out_inst     = inst_mem_q[rd_ptr_q];
    assign out_pc_plus4 = pc_mem_q[rd_ptr_q] + {{(XLEN-3){1'b0}}, 3'b100};

`ifdef FETCHQ_PERF_EN
    logic [31:0]   perf_fetched_q, perf_fetched_d;
    logic [31:0]   perf_flushed_q, perf_flushed_d;
    logic [CW-1:0] discard_s;
    logic [32:0]   flush_sum_s;

    // Saturating counters; a flush counts entries lost, excluding one delivered that cycle.
    always_comb begin
        discard_s   = count_q - {{(CW-1){1'b0}}, pop_s};
        flush_sum_s = {1'b0, perf_flushed_q} + 33'(discard_s);
        if (push_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end else begin
            perf_fetched_d = perf_fetched_q;
        end
        if (redirect_valid) begin
            perf_flushed_d = flush_sum_s[32] ? 32'hFFFF_FFFF : flush_sum_s[31:0];
        end else begin
            perf_flushed_d = perf_flushed_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed vector table, hand sequences, random vs. queue model.
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] fetch_pc;
    logic [2:0]  occupancy;

    logic [7:0]  imem_addr_w;
    logic [31:0] imem_data_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        out_valid_w;
    logic [31:0] out_inst_w;
    logic [31:0] out_pc_w;
    logic [31:0] out_pc_plus4_w;
    logic [31:0] fetch_pc_w;
    logic [2:0]  occupancy_w;

`ifdef FETCHQ_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_fetched_w, perf_flushed_w;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] imem_fn(input logic [7:0] a);
        return {8'hA5, ~a, a, 8'h13};
    endfunction

    assign imem_data   = imem_fn(imem_addr);
    assign imem_data_w = imem_fn(imem_addr_w);

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .fetch_pc(fetch_pc),
        .occupancy(occupancy)
`ifdef FETCHQ_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .IMEM_AW(8)) dut_w (
        .clk(clk), .rst(rst), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_inst(out_inst_w),
        .out_pc(out_pc_w), .out_pc_plus4(out_pc_plus4_w), .fetch_pc(fetch_pc_w),
        .occupancy(occupancy_w)
`ifdef FETCHQ_PERF_EN
        , .perf_fetched(perf_fetched_w), .perf_flushed(perf_flushed_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        bit          rst_before;
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_valid;
        logic [31:0] exp_pc;
        int          exp_occ;
        logic [31:0] exp_fpc;
        bit          chk_fl;
        logic [31:0] exp_fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rb, bit rdy, bit rd, logic [31:0] rpc, bit ev,
                                logic [31:0] epc, int eocc, logic [31:0] efpc,
                                bit cf, logic [31:0] efl);
        vec_t v;
        v = '{rb, rdy, rd, rpc, ev, epc, eocc, efpc, cf, efl};
        vecs.push_back(v);
    endfunction

    // Reference model state for the random phase
    logic [31:0] mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_fet, m_fl;

    initial begin
        rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        redirect_valid_w = 1'b0; redirect_pc_w = 32'd0;

        // Steady stream with out_ready=1
        add(1, 1, 0, 0, 0, 0,  0, 0,  0, 0);
        add(0, 1, 0, 0, 1, 0,  1, 4,  0, 0);
        add(0, 1, 0, 0, 1, 4,  1, 8,  0, 0);
        add(0, 1, 0, 0, 1, 8,  1, 12, 0, 0);
        add(0, 1, 0, 0, 1, 12, 1, 16, 0, 0);
        // Fill with out_ready=0, then drain with no bubble
        add(1, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        add(0, 0, 0, 0, 1, 0,  1, 4,  0, 0);
        add(0, 0, 0, 0, 1, 0,  2, 8,  0, 0);
        add(0, 0, 0, 0, 1, 0,  3, 12, 0, 0);
        add(0, 0, 0, 0, 1, 0,  4, 16, 0, 0);
        add(0, 0, 0, 0, 1, 0,  4, 16, 0, 0);
        add(0, 1, 0, 0, 1, 0,  4, 16, 0, 0);
        add(0, 1, 0, 0, 1, 4,  4, 20, 0, 0);
        add(0, 1, 0, 0, 1, 8,  4, 24, 0, 0);
        add(0, 1, 0, 0, 1, 12, 4, 28, 0, 0);
        add(0, 1, 0, 0, 1, 16, 4, 32, 0, 0);
        // Queue 8,12,16 then redirect to 0x40, then misaligned redirect to 0x43
        add(1, 0, 0, 0,     0, 0,     0, 0,     0, 0);
        add(0, 0, 0, 0,     1, 0,     1, 4,     0, 0);
        add(0, 0, 0, 0,     1, 0,     2, 8,     0, 0);
        add(0, 1, 0, 0,     1, 0,     3, 12,    0, 0);
        add(0, 1, 0, 0,     1, 4,     3, 16,    0, 0);
        add(0, 1, 1, 32'h40, 1, 8,    3, 20,    0, 0);
        add(0, 1, 0, 0,     0, 0,     0, 32'h40, 1, 2);
        add(0, 1, 0, 0,     1, 32'h40, 1, 32'h44, 0, 0);
        add(0, 1, 1, 32'h43, 1, 32'h44, 1, 32'h48, 0, 0);
        add(0, 1, 0, 0,     0, 0,     0, 32'h40, 1, 2);
        add(0, 1, 0, 0,     1, 32'h40, 1, 32'h44, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            out_ready      = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
            check($sformatf("vec%0d fetch_pc", i), 64'(fetch_pc), 64'(vecs[i].exp_fpc));
            check($sformatf("vec%0d imem_addr", i), 64'(imem_addr), 64'(vecs[i].exp_fpc[9:2]));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d out_pc", i), 64'(out_pc), 64'(vecs[i].exp_pc));
                check($sformatf("vec%0d out_pc_plus4", i), 64'(out_pc_plus4), 64'(vecs[i].exp_pc + 32'd4));
                check($sformatf("vec%0d out_inst", i), 64'(out_inst), 64'(imem_fn(vecs[i].exp_pc[9:2])));
            end
`ifdef FETCHQ_PERF_EN
            if (vecs[i].chk_fl)
                check($sformatf("vec%0d perf_flushed", i), 64'(perf_flushed), 64'(vecs[i].exp_fl));
`endif
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;

        // PC wrap-around on the RESET_PC=0xFFFFFFFC instance
        do_reset();
        out_ready = 1'b1;
        #1;
        check("wrap valid0", 64'(out_valid_w), 64'd0);
        check("wrap fpc0", 64'(fetch_pc_w), 64'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap pc1", 64'(out_pc_w), 64'hFFFF_FFFC);
        check("wrap plus4_1", 64'(out_pc_plus4_w), 64'h0);
        check("wrap fpc1", 64'(fetch_pc_w), 64'h0);
        @(posedge clk); #1;
        check("wrap pc2", 64'(out_pc_w), 64'h0);
        check("wrap valid2", 64'(out_valid_w), 64'd1);

        // Asynchronous reset mid-cycle with three entries queued
        do_reset();
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("areset pre occ", 64'(occupancy), 64'd3);
        #2 rst = 1'b0;
        #1;
        check("areset valid", 64'(out_valid), 64'd0);
        check("areset occ", 64'(occupancy), 64'd0);
        check("areset fpc", 64'(fetch_pc), 64'd0);
        check("areset fpc_w", 64'(fetch_pc_w), 64'hFFFF_FFFC);
`ifdef FETCHQ_PERF_EN
        check("areset perf_fetched", 64'(perf_fetched), 64'd0);
        check("areset perf_flushed", 64'(perf_flushed), 64'd0);
`endif
        @(posedge clk); #1;

        // Random traffic against a queue-based model
        do_reset();
        mq.delete();
        m_fpc = 32'd0; m_fet = 32'd0; m_fl = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            bit pop, can_push;
            int sz;
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            #1;
            sz = mq.size();
            check("rnd out_valid", 64'(out_valid), 64'(sz != 0));
            check("rnd occupancy", 64'(occupancy), 64'(sz));
            check("rnd fetch_pc", 64'(fetch_pc), 64'(m_fpc));
            check("rnd imem_addr", 64'(imem_addr), 64'(m_fpc[9:2]));
            if (sz != 0) begin
                check("rnd out_pc", 64'(out_pc), 64'(mq[0]));
                check("rnd out_pc_plus4", 64'(out_pc_plus4), 64'(mq[0] + 32'd4));
                check("rnd out_inst", 64'(out_inst), 64'(imem_fn(mq[0][9:2])));
            end
`ifdef FETCHQ_PERF_EN
            check("rnd perf_fetched", 64'(perf_fetched), 64'(m_fet));
            check("rnd perf_flushed", 64'(perf_flushed), 64'(m_fl));
`endif
            pop      = (sz != 0) && out_ready;
            can_push = (sz < 4) || pop;
            if (redirect_valid) begin
                m_fl  = m_fl + 32'(sz - int'(pop));
                mq.delete();
                m_fpc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(mq.pop_front());
                if (can_push) begin
                    mq.push_back(m_fpc);
                    m_fpc = m_fpc + 32'd4;
                    m_fet = m_fet + 32'd1;
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end that replaces the bare PC register + PC+4 adder + next-PC mux of the single-cycle core.
- Owns the fetch PC and drives the instruction-memory word address each cycle.
- Buffers fetched {pc, instruction} pairs in a DEPTH-entry queue, so decode/execute can stall without losing fetches.
- Accepts a redirect (branch/jump target) that flushes the queue and restarts fetch.

Parameters:
- XLEN, 32, width of PC and of out_pc / out_pc_plus4 / redirect_pc.
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC loaded on reset.
- IMEM_AW, 8, instruction-memory word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset.
- imem_addr  out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]; memory read is combinational, same cycle.
- imem_data  in  32  instruction word at imem_addr.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer accepts head.
- out_inst  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_pc_plus4  out  XLEN  out_pc + 4, modulo 2^XLEN.
- fetch_pc  out  XLEN  current fetch PC, for debug/SSD display.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc = RESET_PC; queue empty; occupancy = 0; out_valid = 0.
  - out_inst, out_pc, out_pc_plus4 are don't-care while out_valid = 0.
  - Reset asserted mid-operation discards all entries immediately, with no further pushes or pops.
- Storage: circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0, plus a count register. occupancy = count.
- Status: out_valid = (count != 0). Head outputs come straight from storage at rd_ptr, with no extra latency.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop). Push is allowed when full only if a pop happens in the same cycle.
- On push:
  - Entry {fetch_pc, imem_data} is written at wr_ptr; wr_ptr advances.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- When full and not popping: fetch_pc holds and imem_addr holds.
- On redirect_valid:
  - Flush takes priority over push and pop.
  - rd_ptr = wr_ptr = 0 and count = 0 next cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; low two bits are forced to zero.
  - A pop handshake in the same cycle counts as delivered to the consumer. The remaining entries are discarded.
  - Consecutive redirects: the last one wins.
- Latency:
  - The first entry after reset or redirect is valid 1 cycle later.
  - Steady-state throughput is 1 instruction/cycle when out_ready is held at 1.
- Single clock domain; no combinational path from out_ready to imem_addr.

Optional Feature:
- Macro: FETCHQ_PERF_EN.
- Defined: adds outputs perf_fetched [31:0] and perf_flushed [31:0], both reset to 0.
  - perf_fetched increments on every push.
  - perf_flushed adds, on each redirect, the number of entries discarded: count minus pop.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, imem returns 0x00000013 everywhere:
  - out_valid rises 1 cycle after release.
  - out_pc sequence is 0, 4, 8, 12.
  - out_pc_plus4 = out_pc + 4.
  - occupancy stays at 1.
- out_ready=0 from reset:
  - Exactly 4 pushes occur; occupancy = 4; fetch_pc = 16 and holds.
  - Raise out_ready: entries drain in order 0, 4, 8, 12, then 16 follows back-to-back with no bubble.
- Queue holding PCs 8, 12, 16 with out_ready=1, then redirect_valid=1 with redirect_pc=0x40:
  - Entry 8 is delivered that cycle.
  - Next cycle occupancy = 0; the following cycle out_pc = 0x40.
  - With FETCHQ_PERF_EN: perf_flushed = 2.
- Misaligned redirect to 0x43: fetch_pc becomes 0x40 and imem_addr = 0x10.
- Wrap-around with XLEN=32 and RESET_PC=0xFFFFFFFC: out_pc sequence is 0xFFFFFFFC then 0x00000000.
- Reset asserted with occupancy = 3:
  - Outputs clear asynchronously before the next edge: out_valid = 0, occupancy = 0, fetch_pc = RESET_PC.
  - With FETCHQ_PERF_EN: counters read 0.
